cr16_regread: RTL and testbench
===============================

CR16_REGREAD -- requirements
Module: cr16_regread

Interface
REQ-001 The block SHALL expose parameter P_REG_WIDTH, default 16, meaning bits per register.
REQ-002 The block SHALL expose parameter P_FILE_WIDTH, default 16, meaning register count; index width IW = $clog2(P_FILE_WIDTH).
REQ-003 The block SHALL have these ports, one per line (name  direction  width  meaning):
  I_CLK  input  1  single clock, all state on rising edge
  I_NRESET  input  1  asynchronous, active-low reset
  I_REG_DATA  input  P_FILE_WIDTH x P_REG_WIDTH  unpacked array of current register contents
  I_REG_BUS  input  P_REG_WIDTH  write data driven to the register file this cycle
  I_REG_ENABLE  input  P_FILE_WIDTH  one-hot-or-zero write enables to the register file this cycle
  I_REQ_VALID  input  1  read request valid
  O_REQ_READY  output  1  block accepts request this cycle
  I_IDX_A  input  IW  operand A register index
  I_IDX_B  input  IW  operand B register index
  O_OP_VALID  output  1  operand pair valid
  I_OP_READY  input  1  consumer accepts operand pair
  O_OP_A  output  P_REG_WIDTH  operand A value
  O_OP_B  output  P_REG_WIDTH  operand B value

Function
REQ-004 Request handshake SHALL complete on a rising edge with I_REQ_VALID && O_REQ_READY; output handshake SHALL complete with O_OP_VALID && I_OP_READY.
REQ-005 O_REQ_READY SHALL equal !O_OP_VALID || I_OP_READY (combinational, single-entry output stage).
REQ-006 Latency SHALL be one cycle: an accepted request SHALL drive O_OP_VALID=1 with its operands on the next cycle.
REQ-007 Captured operand X SHALL be I_REG_BUS when I_REG_ENABLE[I_IDX_X]=1 in the accepting cycle, else I_REG_DATA[I_IDX_X] (write-through bypass).
REQ-008 I_IDX_A == I_IDX_B SHALL yield identical O_OP_A and O_OP_B, including under bypass.
REQ-009 While held (O_OP_VALID=1, I_OP_READY=0), the block SHALL store each operand index; if I_REG_ENABLE[stored index]=1, that operand SHALL update to I_REG_BUS on that edge (held operands track writes).
REQ-010 Output handshake and new request in the same cycle SHALL load the new pair with no bubble; O_OP_VALID stays 1.
REQ-011 Output handshake with no new request SHALL clear O_OP_VALID on the next edge.
REQ-012 Operand registers SHALL NOT change while O_OP_VALID=0 except by new capture.
REQ-013 I_REG_ENABLE with more than one bit set is illegal input; behaviour undefined, an assertion SHALL flag it in simulation.
REQ-014 Index values >= P_FILE_WIDTH (non-power-of-two files) SHALL read as zero and never bypass.
REQ-015 Two-state FSM: EMPTY (O_OP_VALID=0) -> FULL on request accept; FULL -> EMPTY on output handshake without request; FULL -> FULL on hold or handshake-with-request; EMPTY -> EMPTY otherwise.

Reset
REQ-016 I_NRESET low SHALL asynchronously force state EMPTY, O_OP_VALID=0, O_OP_A=0, O_OP_B=0, stored indices=0.
REQ-017 O_REQ_READY SHALL read 1 during and after reset.
REQ-018 Reset asserted mid-hold SHALL discard the held pair; no handshake completes on the edge where reset releases unless request is valid after release.

Structure
REQ-019 A shared package cr16_pkg SHALL hold the state enum (EMPTY, FULL) and default width constants REG_WIDTH=16, FILE_WIDTH=16.
REQ-020 One sub-module cr16_operand_sel SHALL be instantiated twice (A and B): combinational index->value selection with bypass, shared by capture and hold-update paths.
REQ-021 Block SHALL contain no latches; all flops on I_CLK rising edge with I_NRESET async clear.

Verification
REQ-022 Reset, regs R3=0x1234, R7=0xBEEF; request A=3, B=7 -> next cycle O_OP_VALID=1, O_OP_A=0x1234, O_OP_B=0xBEEF.
REQ-023 Request A=5, B=5 while I_REG_ENABLE=0x0020, I_REG_BUS=0xA5A5 -> O_OP_A=O_OP_B=0xA5A5.
REQ-024 Pair held with A=2 (value 0x0001), I_OP_READY=0, write R2=0x00FF -> next cycle O_OP_A=0x00FF, O_OP_VALID=1, O_REQ_READY=0.
REQ-025 Back-to-back requests (1,2),(3,4),(5,6) with I_OP_READY=1 -> three consecutive valid cycles, no bubble, correct values in order.
REQ-026 Hold pair, assert I_NRESET=0 for one cycle mid-hold -> O_OP_VALID=0, O_OP_A=O_OP_B=0 immediately, O_REQ_READY=1.
REQ-027 Random request/ready/write traffic 10k cycles vs. reference model -> zero mismatches; one-hot enable assertion never fires on legal stimulus.

Source files
------------

// File: rtl/cr16_pkg.sv
// Shared types and default sizes for the CR16 operand read stage.
package cr16_pkg;
  localparam int REG_WIDTH  = 16;
  localparam int FILE_WIDTH = 16;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
endpackage

// File: rtl/cr16_operand_sel.sv
// Index -> register value select with write-through bypass. The hit flag lets
// the hold path pick up a write to the stored index without re-reading the file.
module cr16_operand_sel
  import cr16_pkg::*;
#(
  parameter int P_REG_WIDTH  = REG_WIDTH,
  parameter int P_FILE_WIDTH = FILE_WIDTH,
  parameter int IW           = 4
) (
  input  logic [P_REG_WIDTH-1:0]  reg_data [P_FILE_WIDTH],
  input  logic [P_REG_WIDTH-1:0]  reg_bus,
  input  logic [P_FILE_WIDTH-1:0] reg_enable,
  input  logic [IW-1:0]           idx,
  output logic [P_REG_WIDTH-1:0]  value,
  output logic                    hit
);

  // Indices with no matching register fall through to zero and never hit.
  always_comb begin
    value = '0;
    hit   = 1'b0;
    for (int i = 0; i < P_FILE_WIDTH; i++) begin
      if (idx == IW'(i)) begin
        hit   = reg_enable[i];
        value = reg_enable[i] ? reg_bus : reg_data[i];
      end
    end
  end

endmodule

// File: rtl/cr16_regread.sv
// Operand read stage: one-cycle capture of an A/B pair into a single-entry
// output register, with write-through bypass at capture and while held.
module cr16_regread
  import cr16_pkg::*;
#(
  parameter  int P_REG_WIDTH  = REG_WIDTH,
  parameter  int P_FILE_WIDTH = FILE_WIDTH,
  localparam int IW           = (P_FILE_WIDTH > 1) ? $clog2(P_FILE_WIDTH) : 1
) (
  input  logic                    I_CLK,
  input  logic                    I_NRESET,
  input  logic [P_REG_WIDTH-1:0]  I_REG_DATA [P_FILE_WIDTH],
  input  logic [P_REG_WIDTH-1:0]  I_REG_BUS,
  input  logic [P_FILE_WIDTH-1:0] I_REG_ENABLE,
  input  logic                    I_REQ_VALID,
  output logic                    O_REQ_READY,
  input  logic [IW-1:0]           I_IDX_A,
  input  logic [IW-1:0]           I_IDX_B,
  output logic                    O_OP_VALID,
  input  logic                    I_OP_READY,
  output logic [P_REG_WIDTH-1:0]  O_OP_A,
  output logic [P_REG_WIDTH-1:0]  O_OP_B
);

  state_t                 state, state_nx;
  logic                   accept, out_hs;
  logic [IW-1:0]          idx_a_q, idx_b_q, sel_idx_a, sel_idx_b;
  logic [P_REG_WIDTH-1:0] val_a, val_b;
  logic                   hit_a, hit_b;

  assign accept = I_REQ_VALID && O_REQ_READY;
  assign out_hs = O_OP_VALID && I_OP_READY;

  // One selector per operand serves both capture (live index) and hold (stored index).
  assign sel_idx_a = accept ? I_IDX_A : idx_a_q;
  assign sel_idx_b = accept ? I_IDX_B : idx_b_q;

  cr16_operand_sel #(.P_REG_WIDTH(P_REG_WIDTH), .P_FILE_WIDTH(P_FILE_WIDTH), .IW(IW)) u_sel_a (
    .reg_data   (I_REG_DATA),
    .reg_bus    (I_REG_BUS),
    .reg_enable (I_REG_ENABLE),
    .idx        (sel_idx_a),
    .value      (val_a),
    .hit        (hit_a)
  );

  cr16_operand_sel #(.P_REG_WIDTH(P_REG_WIDTH), .P_FILE_WIDTH(P_FILE_WIDTH), .IW(IW)) u_sel_b (
    .reg_data   (I_REG_DATA),
    .reg_bus    (I_REG_BUS),
    .reg_enable (I_REG_ENABLE),
    .idx        (sel_idx_b),
    .value      (val_b),
    .hit        (hit_b)
  );

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) state <= EMPTY;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   if (accept) state_nx = FULL;
      FULL:    if (out_hs && !accept) state_nx = EMPTY;
      default: state_nx = EMPTY;
    endcase
  end

  always_comb begin
    O_OP_VALID  = (state == FULL);
    O_REQ_READY = (state != FULL) || I_OP_READY;
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      O_OP_A  <= '0;
      O_OP_B  <= '0;
      idx_a_q <= '0;
      idx_b_q <= '0;
    end else if (accept) begin
      O_OP_A  <= val_a;
      O_OP_B  <= val_b;
      idx_a_q <= I_IDX_A;
      idx_b_q <= I_IDX_B;
    end else if (state == FULL) begin
      if (hit_a) O_OP_A <= I_REG_BUS;
      if (hit_b) O_OP_B <= I_REG_BUS;
    end
  end

  a_enable_onehot0: assert property (@(posedge I_CLK) disable iff (!I_NRESET) $onehot0(I_REG_ENABLE));

endmodule

// File: tb/tb_cr16_regread.sv
// Bench for cr16_regread: directed scenarios plus random traffic checked
// every cycle against a transaction-level model of the operand stage.
module tb_cr16_regread;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] regs   [16];
  logic [15:0] regs12 [12];
  logic [15:0] bus;
  logic [15:0] en;
  logic        req_valid, op_ready;
  logic [3:0]  idx_a, idx_b;
  logic        req_ready, op_valid, req_ready12, op_valid12;
  logic [15:0] op_a, op_b, op_a12, op_b12;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb for (int i = 0; i < 12; i++) regs12[i] = regs[i];

  cr16_regread dut (
    .I_CLK(clk), .I_NRESET(rst_n), .I_REG_DATA(regs), .I_REG_BUS(bus), .I_REG_ENABLE(en),
    .I_REQ_VALID(req_valid), .O_REQ_READY(req_ready), .I_IDX_A(idx_a), .I_IDX_B(idx_b),
    .O_OP_VALID(op_valid), .I_OP_READY(op_ready), .O_OP_A(op_a), .O_OP_B(op_b)
  );

  cr16_regread #(.P_REG_WIDTH(16), .P_FILE_WIDTH(12)) dut12 (
    .I_CLK(clk), .I_NRESET(rst_n), .I_REG_DATA(regs12), .I_REG_BUS(bus), .I_REG_ENABLE(en[11:0]),
    .I_REQ_VALID(req_valid), .O_REQ_READY(req_ready12), .I_IDX_A(idx_a), .I_IDX_B(idx_b),
    .O_OP_VALID(op_valid12), .I_OP_READY(op_ready), .O_OP_A(op_a12), .O_OP_B(op_b12)
  );

  // Model: the register file plus "the pair last handed out" and its indices.
  logic        mv;
  logic [15:0] ma, mb;
  logic [3:0]  mia, mib;
  wire         m_acc = req_valid && (!mv || op_ready);

  function automatic logic [15:0] rd(input logic [3:0] i);
    return en[i] ? bus : regs[i];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv <= 1'b0; ma <= '0; mb <= '0; mia <= '0; mib <= '0;
      for (int k = 0; k < 16; k++) regs[k] <= '0;
    end else begin
      if (m_acc) begin
        mv <= 1'b1; ma <= rd(idx_a); mb <= rd(idx_b); mia <= idx_a; mib <= idx_b;
      end else begin
        if (mv && en[mia]) ma <= bus;
        if (mv && en[mib]) mb <= bus;
        if (mv && op_ready) mv <= 1'b0;
      end
      for (int k = 0; k < 16; k++) if (en[k]) regs[k] <= bus;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Enter at posedge+1, compare against the model mid-cycle, leave at next posedge+1.
  task automatic step(input logic rv, input logic [3:0] ia, input logic [3:0] ib,
                      input logic ordy, input logic [15:0] e, input logic [15:0] b);
    req_valid = rv; idx_a = ia; idx_b = ib; op_ready = ordy; en = e; bus = b;
    @(negedge clk);
    chk("model_valid", 32'(op_valid), 32'(mv));
    chk("model_ready", 32'(req_ready), 32'(!mv || op_ready));
    chk("model_op_a", 32'(op_a), 32'(ma));
    chk("model_op_b", 32'(op_b), 32'(mb));
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [3:0] r, input logic [15:0] v);
    step(1'b0, 4'd0, 4'd0, 1'b0, 16'd1 << r, v);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 0; op_ready = 0; idx_a = 0; idx_b = 0; en = 0; bus = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(op_valid), 0);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_op_a", 32'(op_a), 0);
    chk("rst_op_b", 32'(op_b), 0);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0);

    // Basic read after writing the file.
    wr(3, 16'h1234); wr(7, 16'hBEEF);
    step(1, 3, 7, 0, 0, 0);
    chk("basic_valid", 32'(op_valid), 1);
    chk("basic_op_a", 32'(op_a), 32'h1234);
    chk("basic_op_b", 32'(op_b), 32'hBEEF);
    step(0, 0, 0, 1, 0, 0);
    chk("drain_valid", 32'(op_valid), 0);

    // Same index on both operands, bypassed from the write bus.
    step(1, 5, 5, 1, 16'h0020, 16'hA5A5);
    chk("bypass_op_a", 32'(op_a), 32'hA5A5);
    chk("bypass_op_b", 32'(op_b), 32'hA5A5);
    step(0, 0, 0, 1, 0, 0);

    // Held operand picks up a write to its register.
    wr(2, 16'h0001);
    step(1, 2, 7, 0, 0, 0);
    chk("hold_pre_a", 32'(op_a), 32'h0001);
    step(0, 0, 0, 0, 16'h0004, 16'h00FF);
    chk("hold_op_a", 32'(op_a), 32'h00FF);
    chk("hold_op_b", 32'(op_b), 32'hBEEF);
    chk("hold_valid", 32'(op_valid), 1);
    chk("hold_ready", 32'(req_ready), 0);
    step(0, 0, 0, 1, 0, 0);

    // Back-to-back requests with no bubble.
    for (int k = 1; k <= 6; k++) wr(4'(k), 16'h1000 + 16'(k));
    step(1, 1, 2, 1, 0, 0);
    chk("b2b0_valid", 32'(op_valid), 1);
    chk("b2b0", {op_a, op_b}, 32'h1001_1002);
    step(1, 3, 4, 1, 0, 0);
    chk("b2b1_valid", 32'(op_valid), 1);
    chk("b2b1", {op_a, op_b}, 32'h1003_1004);
    step(1, 5, 6, 1, 0, 0);
    chk("b2b2_valid", 32'(op_valid), 1);
    chk("b2b2", {op_a, op_b}, 32'h1005_1006);
    step(0, 0, 0, 1, 0, 0);
    chk("b2b_end_valid", 32'(op_valid), 0);
    chk("b2b_end_keep", {op_a, op_b}, 32'h1005_1006);

    // Reset in the middle of a hold drops the pair immediately.
    step(1, 3, 4, 0, 0, 0);
    chk("pre_rst_valid", 32'(op_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(op_valid), 0);
    chk("midrst_op_a", 32'(op_a), 0);
    chk("midrst_op_b", 32'(op_b), 0);
    chk("midrst_ready", 32'(req_ready), 1);
    req_valid = 0; op_ready = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    chk("post_rst_valid", 32'(op_valid), 0);

    // 12-entry file: out-of-range indices read zero and never bypass.
    wr(11, 16'h0B0B);
    step(1, 13, 11, 0, 0, 0);
    chk("oor_a", 32'(op_a12), 0);
    chk("oor_b", 32'(op_b12), 32'h0B0B);
    step(0, 0, 0, 1, 0, 0);
    step(1, 13, 13, 1, 16'h2000, 16'h7777);
    chk("oor_bypass_16", {op_a, op_b}, 32'h7777_7777);
    chk("oor_bypass_12", {op_a12, op_b12}, 32'h0);
    chk("oor_valid_12", 32'(op_valid12), 1);
    step(0, 0, 0, 1, 0, 0);

    // Random legal traffic.
    for (int n = 0; n < 10000; n++) begin
      logic [15:0] e;
      e = ($urandom_range(0, 2) == 0) ? (16'd1 << $urandom_range(0, 15)) : 16'd0;
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), e, 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
